dma_priority_arbiter: RTL

//  Parametrised DMA channel arbiter; next generation of the 4-channel priority logic.

---
 rtl/dma_arb_pkg.sv | 21 ++
 rtl/dma_rotate_encoder.sv | 43 ++++
 rtl/dma_priority_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel priority arbiter.
package dma_arb_pkg;

   localparam int DEF_NUM_CH = 4;
   localparam int MAX_CH     = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GRANT,
      RELEASE
   } arb_state_e;

   function automatic logic [MAX_CH-1:0] onehot(input logic [3:0] idx);
      logic [MAX_CH-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/dma_rotate_encoder.sv
// Combinational winner search: rotate requests so the start pointer sits at bit 0,
// take the first set bit, then map the offset back to a channel index.
module dma_rotate_encoder
   import dma_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = $clog2(NUM_CH)
)
(
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   start,
   input  logic              rotate,
   output logic [CH_W-1:0]   winner,
   output logic              found
);

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [CH_W-1:0]     base;
   logic [CH_W-1:0]     offset;
   logic [CH_W:0]       sum;

   // Fixed mode is simply a search that always starts at channel 0.
   assign base    = rotate ? start : '0;
   assign req_dbl = {req, req} >> base;
   assign req_rot = req_dbl[NUM_CH-1:0];

   always_comb begin
      offset = '0;
      found  = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = CH_W'(i);
            found  = 1'b1;
         end
      end
   end

   assign sum    = {1'b0, base} + {1'b0, offset};
   assign winner = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH))
                                              : sum[CH_W-1:0];

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: HRQ/HLDA handshake, fixed or rotating priority, one-hot DACK.
// Optional software request inputs are enabled by defining DMA_ARB_SW_REQ_EN.
module dma_priority_arbiter
   import dma_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = $clog2(NUM_CH)
)
(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic [NUM_CH-1:0] chMask,
`ifdef DMA_ARB_SW_REQ_EN
   input  logic [NUM_CH-1:0] swReq,
`endif
   input  logic              priorityType,
   input  logic              assertDACK,
   input  logic              transferDone,
   input  logic              HLDA,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic [CH_W-1:0]   activeCh,
   output logic              grantValid
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [CH_W-1:0]   active_q;
   logic [CH_W-1:0]   ptr_q;
   logic [CH_W-1:0]   next_ptr;
   logic [CH_W-1:0]   winner;
   logic              found;
   logic              latch_grant;
   logic              any_req;
   logic [NUM_CH-1:0] eff_req;
   logic [NUM_CH-1:0] hold_req;

   // hold_req lists the lines that keep an existing grant alive; masking is not applied.
`ifdef DMA_ARB_SW_REQ_EN
   assign eff_req  = (DREQ | swReq) & ~chMask;
   assign hold_req = DREQ | swReq;
`else
   assign eff_req  = DREQ & ~chMask;
   assign hold_req = DREQ;
`endif

   assign any_req  = |eff_req;
   assign next_ptr = (active_q == CH_W'(NUM_CH - 1)) ? '0 : active_q + CH_W'(1);

   dma_rotate_encoder #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_encoder (
      .req    (eff_req),
      .start  (ptr_q),
      .rotate (priorityType),
      .winner (winner),
      .found  (found)
   );

   always_comb begin
      state_d     = state_q;
      latch_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) state_d = REQ;
         end
         REQ: begin
            if (!any_req) begin
               state_d = IDLE;
            end else if (HLDA && found) begin
               state_d     = GRANT;
               latch_grant = 1'b1;
            end
         end
         GRANT: begin
            if (transferDone || !hold_req[active_q] || !HLDA) state_d = RELEASE;
         end
         RELEASE: begin
            state_d = any_req ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The served channel drops to lowest priority as soon as its grant ends.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         active_q <= '0;
         ptr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (latch_grant) active_q <= winner;
         if (state_q == GRANT && state_d == RELEASE) ptr_q <= next_ptr;
      end
   end

   assign HRQ        = (state_q == REQ) || (state_q == GRANT) || (state_q == RELEASE && any_req);
   assign grantValid = (state_q == GRANT);
   assign activeCh   = active_q;
   assign DACK       = (grantValid && assertDACK) ? NUM_CH'(onehot(4'(active_q))) : '0;

endmodule
